// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM state encodings, saturation limits and
// magnitude helpers for the signed sequential divider.
// Helpers operate at XW bits. Callers sign-extend into that width and
// truncate the result back to their own width.
package div_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned XW     = 64;

    // FSM encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    // Saturation constants at the default width
    localparam logic [DW_DEF-1:0] Q_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
    localparam logic [DW_DEF-1:0] Q_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

    // Largest positive signed value at width w, as an unsigned number
    function automatic logic [XW-1:0] sat_max(input int unsigned w);
        return (XW'(1) << (w - 1)) - XW'(1);
    endfunction

    // Magnitude of the most negative signed value at width w
    function automatic logic [XW-1:0] sat_min(input int unsigned w);
        return XW'(1) << (w - 1);
    endfunction

    function automatic logic [XW-1:0] negate(input logic [XW-1:0] x);
        return XW'(0) - x;
    endfunction

    // The argument is already sign-extended to XW.
    // The most negative value therefore never wraps.
    function automatic logic [XW-1:0] abs_val(input logic [XW-1:0] x);
        return x[XW-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one combinational restoring-division step.
//   rem      in   DW    partial remainder, always < divisor
//   din      in   1     next dividend bit, shifted in at the LSB
//   divisor  in   DW    divisor magnitude
//   rem_next out  DW    updated partial remainder
//   qbit     out  1     quotient bit for this step
module restoring_div_step
    import div_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] rem,
    input  logic          din,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_next,
    output logic          qbit
);

    // The shifted value is below 2*divisor, so DW+1 bits hold it.
    // The sign of the trial subtraction is therefore exact.
    logic [DW:0] shifted;
    logic [DW:0] trial;

    always_comb begin
        shifted  = {rem, din};
        trial    = shifted - {1'b0, divisor};
        qbit     = ~trial[DW];
        rem_next = qbit ? trial[DW-1:0] : shifted[DW-1:0];
    end

endmodule

// File: rtl/signed_divider.sv
// signed_divider: divides a 2*DW-bit signed dividend by a DW-bit signed
// divisor. The quotient is truncated toward zero. The remainder takes
// the sign of the dividend. One quotient bit is produced per cycle.
//   CLK, RST             clock, synchronous active-high reset
//   enable               clock enable; when low, all state holds
//   in_valid/in_ready    handshake for A (2*DW bits) and B (DW bits)
//   out_valid/out_ready  handshake for Q, R, err_dz and err_ovf
// Build option: DIV_SATURATE_EN. When defined, an error saturates Q to
// the signed limit. When undefined, an error gives Q=0. R is 0 on any
// error in both builds.
module signed_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            enable,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] A,
    input  logic [DW-1:0]   B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   Q,
    output logic [DW-1:0]   R,
    output logic            err_dz,
    output logic            err_ovf
);

    localparam int unsigned CW = $clog2(DW);

    logic [2:0]      state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [2*DW-1:0] a_q,       a_d;
    logic [DW-1:0]   b_q,       b_d;
    logic            sign_q,    sign_d;
    logic [DW-1:0]   bmag_q,    bmag_d;
    logic [DW-1:0]   lo_q,      lo_d;
    logic [DW-1:0]   rem_q,     rem_d;
    logic [DW-1:0]   quot_q,    quot_d;
    logic            pdz_q,     pdz_d;
    logic            povf_q,    povf_d;
    logic            in_rdy_q,  in_rdy_d;
    logic            out_vld_q, out_vld_d;
    logic [DW-1:0]   q_q,       q_d;
    logic [DW-1:0]   r_q,       r_d;
    logic            dz_q,      dz_d;
    logic            ovf_q,     ovf_d;

    logic [2*DW-1:0] a_mag;
    logic [DW-1:0]   b_mag;
    logic [DW-1:0]   rem_next;
    logic            qbit;
    logic            ovf_now;
    logic            err;
`ifdef DIV_SATURATE_EN
    logic            sat_neg;
`endif

    // Single shared step, iterated by the FSM
    restoring_div_step #(.DW(DW)) u_step (
        .rem      (rem_q),
        .din      (lo_q[DW-1]),
        .divisor  (bmag_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        bmag_d    = bmag_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        pdz_d     = pdz_q;
        povf_d    = povf_q;
        in_rdy_d  = in_rdy_q;
        out_vld_d = out_vld_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        a_mag     = (2*DW)'(abs_val(XW'(signed'(a_q))));
        b_mag     = DW'(abs_val(XW'(signed'(b_q))));
        ovf_now   = 1'b0;
        err       = 1'b0;
`ifdef DIV_SATURATE_EN
        sat_neg   = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_rdy_q) begin
                    a_d      = A;
                    b_d      = B;
                    sign_d   = A[2*DW-1] ^ B[DW-1];
                    in_rdy_d = 1'b0;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                bmag_d = b_mag;
                lo_d   = a_mag[DW-1:0];
                rem_d  = a_mag[2*DW-1:DW];
                quot_d = '0;
                pdz_d  = 1'b0;
                povf_d = 1'b0;
                if (b_q == '0) begin
                    pdz_d   = 1'b1;
                    state_d = S_FIX;
                end else if (a_mag[2*DW-1:DW] >= b_mag) begin
                    // The quotient needs more than DW bits
                    povf_d  = 1'b1;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = CW'(DW - 1);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rem_d  = rem_next;
                quot_d = {quot_q[DW-2:0], qbit};
                lo_d   = {lo_q[DW-2:0], 1'b0};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A negative result may reach one step further than a positive one
                ovf_now = sign_q ? (quot_q > DW'(sat_min(DW)))
                                 : (quot_q > DW'(sat_max(DW)));
                dz_d  = pdz_q;
                ovf_d = ~pdz_q & (povf_q | ovf_now);
                err   = pdz_q | povf_q | ovf_now;
                if (err) begin
`ifdef DIV_SATURATE_EN
                    // For divide by zero, the sign of A sets the saturation direction
                    sat_neg = pdz_q ? a_q[2*DW-1] : sign_q;
                    q_d     = sat_neg ? DW'(sat_min(DW)) : DW'(sat_max(DW));
`else
                    q_d     = '0;
`endif
                    r_d = '0;
                end else begin
                    q_d = sign_q      ? (DW'(0) - quot_q) : quot_q;
                    r_d = a_q[2*DW-1] ? (DW'(0) - rem_q)  : rem_q;
                end
                out_vld_d = 1'b1;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    in_rdy_d  = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                in_rdy_d = 1'b1;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            bmag_q    <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            pdz_q     <= 1'b0;
            povf_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sign_q    <= sign_d;
            bmag_q    <= bmag_d;
            lo_q      <= lo_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            pdz_q     <= pdz_d;
            povf_q    <= povf_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld_q;
    assign Q         = q_q;
    assign R         = r_q;
    assign err_dz    = dz_q;
    assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed and random checks of signed_divider at DW=16.
// Expected values for the error cases depend on DIV_SATURATE_EN.
module tb_signed_divider;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [15:0] R;
    logic        err_dz;
    logic        err_ovf;

    int checks = 0;
    int errors = 0;

`ifdef DIV_SATURATE_EN
    localparam logic [15:0] SAT_P = 16'h7FFF;
    localparam logic [15:0] SAT_N = 16'h8000;
`else
    localparam logic [15:0] SAT_P = 16'h0000;
    localparam logic [15:0] SAT_N = 16'h0000;
`endif

    signed_divider #(.DW(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .err_dz    (err_dz),
        .err_ovf   (err_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one operand pair and take the accept edge
    task automatic start(input logic [31:0] a, input logic [15:0] b);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept to out_valid. Enable drops for 3 cycles at stall_at.
    task automatic wait_out(input int stall_at, output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            enable = (stall_at < 0) || (lat < stall_at) || (lat >= stall_at + 3);
            @(posedge CLK);
            #1;
            lat++;
        end
        enable = 1'b1;
        check("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_release", 32'(in_ready), 32'd1);
        check("out_valid_after_release", 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic edz, input logic eovf, input int elat, input int stall_at);
        int lat;
        start(a, b);
        wait_out(stall_at, lat);
        check({tag, "_Q"},   32'(Q), 32'(eq));
        check({tag, "_R"},   32'(R), 32'(er));
        check({tag, "_dz"},  32'(err_dz), 32'(edz));
        check({tag, "_ovf"}, 32'(err_ovf), 32'(eovf));
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        release_out();
    endtask

    // Reference result from integer division at 64 bits
    task automatic model(input logic [31:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ovf, output int lat);
        longint sa, sb, ma, mb, qe, re;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        dz  = 1'b0;
        ovf = 1'b0;
        q   = '0;
        r   = '0;
        if (sb == 0) begin
            dz  = 1'b1;
            lat = 2;
            q   = (sa < 0) ? SAT_N : SAT_P;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            lat = ((ma >>> 16) >= mb) ? 2 : 18;
            qe  = sa / sb;
            re  = sa % sb;
            if (qe > 32767 || qe < -32768) begin
                ovf = 1'b1;
                q   = (qe < 0) ? SAT_N : SAT_P;
            end else begin
                q = 16'(qe);
                r = 16'(re);
            end
        end
    endtask

    initial begin
        logic [15:0] mq, mr;
        logic        mdz, movf;
        int          mlat;
        logic [31:0] ra;
        logic [15:0] rb;

        RST       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Q",         32'(Q),         32'd0);
        check("rst_R",         32'(R),         32'd0);
        check("rst_dz",        32'(err_dz),    32'd0);
        check("rst_ovf",       32'(err_ovf),   32'd0);

        // Directed vectors
        run("p100_7",   32'd100,        16'd7,      16'd14,   16'd2,    1'b0, 1'b0, 18, -1);
        run("n100_7",   32'hFFFFFF9C,   16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18, -1);
        run("p100_n7",  32'd100,        16'hFFF9,   16'hFFF2, 16'd2,    1'b0, 1'b0, 18, -1);
        run("min_1",    32'hFFFF8000,   16'd1,      16'h8000, 16'd0,    1'b0, 1'b0, 18, -1);
        run("p8000_1",  32'h00008000,   16'd1,      SAT_P,    16'd0,    1'b0, 1'b1, 18, -1);
        run("p10000_1", 32'h00010000,   16'd1,      SAT_P,    16'd0,    1'b0, 1'b1, 2,  -1);
        run("n5_0",     32'hFFFFFFFB,   16'd0,      SAT_N,    16'd0,    1'b1, 1'b0, 2,  -1);
        run("n1000_n3", 32'hFFFFFC18,   16'hFFFD,   16'd333,  16'hFFFF, 1'b0, 1'b0, 18, -1);

        // Backpressure: the result holds and a waiting input is not taken
        begin
            int lat;
            start(32'd100, 16'd7);
            wait_out(-1, lat);
            A        = 32'd1000;
            B        = 16'd3;
            in_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge CLK);
                #1;
                check("bp_Q",         32'(Q),         32'd14);
                check("bp_R",         32'(R),         32'd2);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_in_ready",  32'(in_ready),  32'd0);
            end
            in_valid = 1'b0;
            release_out();
        end

        // Reset in the middle of an iteration aborts it
        start(32'd1000, 16'd3);
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_Q",         32'(Q),         32'd0);
        check("abort_R",         32'(R),         32'd0);
        check("abort_dz",        32'(err_dz),    32'd0);

        // Three stalled cycles in the middle of ITER add exactly three to the latency
        run("stall",    32'd1000,       16'd3,      16'd333,  16'd1,    1'b0, 1'b0, 21, 5);

        // Random vectors against the reference model
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom;
                1:       ra = 32'(signed'(20'($urandom)));
                2:       ra = 32'(signed'(16'($urandom)));
                default: ra = 32'(signed'(24'($urandom)));
            endcase
            if ($urandom_range(0, 7) == 0) rb = 16'($urandom_range(0, 3));
            else                           rb = 16'($urandom);
            model(ra, rb, mq, mr, mdz, movf, mlat);
            run("rand", ra, rb, mq, mr, mdz, movf, mlat, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
